// File: rtl/corescore_pkg.sv
// Shared types and constants for the stream emitter and its UART serialiser.
package corescore_pkg;

  // UART transmitter states
  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // Frame geometry: 8 data bits framed by one start and one stop bit
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Width of an index into n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/corescore_uart_tx.sv
// UART serialiser: takes one byte on a valid/ready handshake and shifts it out
// as start bit, 8 data bits LSB first, stop bit. A byte offered at the last
// cycle of a stop bit is taken immediately so frames run back-to-back.
module corescore_uart_tx
  import corescore_pkg::*;
#(
  parameter int CLKS_PER_BIT = 278
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_uart_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  uart_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [BIT_W-1:0] bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             cnt_last;

  assign cnt_last  = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
  // A byte can be taken when idle or in the final cycle of the stop bit
  assign o_ready   = (state_reg == UART_IDLE) || ((state_reg == UART_STOP) && cnt_last);
  assign o_uart_tx = tx_reg;

  // State, counters and the line flop, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= UART_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic; the line value is computed here and registered above
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    case (state_reg)
      UART_IDLE: begin
        tx_next  = 1'b1;
        cnt_next = '0;
        if (i_valid) begin
          state_next = UART_START;
          shift_next = i_data;
          bit_next   = '0;
          tx_next    = 1'b0;
        end
      end
      UART_START: begin
        if (cnt_last) begin
          state_next = UART_DATA;
          cnt_next   = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      UART_DATA: begin
        if (cnt_last) begin
          cnt_next = '0;
          if (bit_reg == BIT_W'(DATA_BITS - 1)) begin
            state_next = UART_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_reg + 1'b1;
            tx_next    = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      UART_STOP: begin
        if (cnt_last) begin
          cnt_next = '0;
          bit_next = '0;
          if (i_valid) begin
            state_next = UART_START;
            shift_next = i_data;
            tx_next    = 1'b0;
          end else begin
            state_next = UART_IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = UART_IDLE;
        cnt_next   = '0;
        bit_next   = '0;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/corescore_stream_emitter.sv
// Multi-channel AXI-stream byte collector feeding a UART. A round-robin
// arbiter grants one channel for a whole packet, bytes go through a small
// FIFO, and the UART serialiser drains it one frame at a time.
module corescore_stream_emitter
  import corescore_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 278
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [8*CHANNELS-1:0]         i_tdata,
  input  logic [CHANNELS-1:0]           i_tlast,
  input  logic [CHANNELS-1:0]           i_tvalid,
  output logic [CHANNELS-1:0]           o_tready,
  output logic                          o_uart_tx,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = idx_width(CHANNELS);

  // Arbiter state
  logic          grant_valid_reg, grant_valid_next;
  logic [CW-1:0] grant_idx_reg, grant_idx_next;
  logic [CW-1:0] ptr_reg, ptr_next;
  logic          arb_found;
  logic [CW-1:0] arb_idx;
  int            arb_cand;

  // Selected stream and handshake
  logic [7:0]    ch_data [CHANNELS];
  logic [7:0]    sel_data;
  logic          sel_last;
  logic          push;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg, level_next;
  logic          fifo_full, fifo_empty;
  logic          pop;
  logic [7:0]    fifo_rd_data;
  logic          uart_ready;

  assign fifo_full  = (level_reg == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_reg == '0);

  // Per-channel data slices and ready flags. Ready depends only on the grant
  // and level registers, so there is no path from any tvalid.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign ch_data[gi]  = i_tdata[8*gi +: 8];
      assign o_tready[gi] = grant_valid_reg && (grant_idx_reg == CW'(gi)) && !fifo_full;
    end
  endgenerate

  assign sel_data = ch_data[grant_idx_reg];
  assign sel_last = i_tlast[grant_idx_reg];
  assign push     = |(i_tvalid & o_tready);

  // Round-robin search: first valid channel at or above the pointer, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      arb_cand = (int'(ptr_reg) + k) % CHANNELS;
      if (!arb_found && i_tvalid[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = CW'(arb_cand);
      end
    end
  end

  // Grant is taken only when free and released on the tlast handshake, which
  // leaves one cycle with every ready low while the next arbitration happens
  always_comb begin
    grant_valid_next = grant_valid_reg;
    grant_idx_next   = grant_idx_reg;
    ptr_next         = ptr_reg;
    if (!grant_valid_reg) begin
      if (arb_found) begin
        grant_valid_next = 1'b1;
        grant_idx_next   = arb_idx;
        ptr_next         = CW'((int'(arb_idx) + 1) % CHANNELS);
      end
    end else if (push && sel_last) begin
      grant_valid_next = 1'b0;
    end
  end

  // Arbiter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_valid_reg <= 1'b0;
      grant_idx_reg   <= '0;
      ptr_reg         <= '0;
    end else begin
      grant_valid_reg <= grant_valid_next;
      grant_idx_reg   <= grant_idx_next;
      ptr_reg         <= ptr_next;
    end
  end

  // Occupancy update; a simultaneous push and pop leaves it unchanged
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // FIFO pointers and level; reset discards any buffered bytes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  // Storage array; contents need no reset because the pointers gate them
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg] <= sel_data;
  end

  // Head of the FIFO is read directly so an idle UART starts the very next edge
  assign fifo_rd_data = mem[rd_ptr_reg];
  assign pop          = uart_ready && !fifo_empty;
  assign o_fifo_level = level_reg;

  corescore_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (!fifo_empty),
    .i_data   (fifo_rd_data),
    .o_ready  (uart_ready),
    .o_uart_tx(o_uart_tx)
  );

endmodule

// File: tb/tb_corescore_stream_emitter.sv
// Directed bench for corescore_stream_emitter: 2 channels, 4-deep FIFO,
// 4 clocks per UART bit.
module tb_corescore_stream_emitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tdata;
  logic [1:0]  tlast;
  logic [1:0]  tvalid;
  logic [1:0]  tready;
  logic        tx;
  logic [2:0]  level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // UART receiver model state
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  bit         rx_busy = 1'b0;
  int         rx_pos;
  int         rx_start_cyc;
  logic [7:0] rx_shift;

  typedef struct {
    logic [1:0]  tvalid;
    logic [1:0]  tlast;
    logic [15:0] tdata;
    logic        exp_tx;
    logic [1:0]  exp_tready;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t vecs[43];
  // Frame for 0xA5: start, 1,0,1,0,0,1,0,1 (LSB first), stop
  int fbits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  corescore_stream_emitter #(
    .CHANNELS    (2),
    .FIFO_DEPTH  (4),
    .CLKS_PER_BIT(4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tdata     (tdata),
    .i_tlast     (tlast),
    .i_tvalid    (tvalid),
    .o_tready    (tready),
    .o_uart_tx   (tx),
    .o_fifo_level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART receiver: samples every cycle, decodes mid-bit, aborts on reset
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (tx === 1'b0) begin
          rx_busy      = 1'b1;
          rx_pos       = 0;
          rx_start_cyc = cyc;
        end
      end else begin
        rx_pos++;
        if (rx_pos == 2) begin
          check("rx_start_bit", tx, 1'b0);
        end else if (rx_pos >= 6 && rx_pos <= 34 && (rx_pos % 4) == 2) begin
          rx_shift = {tx, rx_shift[7:1]};
        end else if (rx_pos == 38) begin
          check("rx_stop_bit", tx, 1'b1);
        end else if (rx_pos == 39) begin
          rx_q.push_back(rx_shift);
          rx_start_q.push_back(rx_start_cyc);
          $display("rx byte %02h frame start cycle %0d", rx_shift, rx_start_cyc);
          rx_busy = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    tvalid = '0;
    tlast  = '0;
    tdata  = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    rx_q.delete();
    rx_start_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_rx_count", rx_q.size(), n);
  endtask

  task automatic check_rx(input string name, input int idx, input logic [7:0] exp);
    if (idx < rx_q.size()) check(name, rx_q[idx], exp);
    else check(name, 32'hFFFF_FFFF, exp);
  endtask

  // Single byte 0xA5 on ch0: cycle-exact line waveform from the vector table
  task automatic test_single();
    do_reset();
    for (int r = 0; r < 43; r++) begin
      tvalid = vecs[r].tvalid;
      tlast  = vecs[r].tlast;
      tdata  = vecs[r].tdata;
      tick();
      check($sformatf("single_tx[%0d]", r), tx, vecs[r].exp_tx);
      check($sformatf("single_tready[%0d]", r), tready, vecs[r].exp_tready);
      check($sformatf("single_level[%0d]", r), level, vecs[r].exp_level);
    end
    wait_rx(1, 20);
    check_rx("single_byte", 0, 8'hA5);
  endtask

  // Both channels continuously valid with 3-byte packets
  task automatic test_rr();
    int seq_exp[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic [7:0] bytes_exp[9] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h13, 8'h14, 8'h15};
    int seq_got[$];
    int idx[2];
    int gap_state;
    int k;
    do_reset();
    idx = '{0, 0};
    gap_state = 0;
    k = 0;
    while (seq_got.size() < 9 && k < 2000) begin
      for (int c = 0; c < 2; c++) begin
        tvalid[c]      = (idx[c] < 6);
        tdata[8*c +: 8] = 8'(16 * (c + 1) + idx[c]);
        tlast[c]       = ((idx[c] % 3) == 2);
      end
      if (gap_state == 1) begin
        check("rr_bubble", tready, 2'b00);
        gap_state = 2;
      end else if (gap_state == 2) begin
        check("rr_regrant", (tready != 2'b00) || (level == 3'd4), 1'b1);
        gap_state = 0;
      end
      for (int c = 0; c < 2; c++) begin
        if (tvalid[c] && tready[c]) begin
          seq_got.push_back(c);
          if (tlast[c] && seq_got.size() < 9) gap_state = 1;
          idx[c]++;
        end
      end
      tick();
      k++;
    end
    tvalid = '0;
    check("rr_handshakes", seq_got.size(), 9);
    for (int i = 0; i < 9 && i < seq_got.size(); i++)
      check($sformatf("rr_order[%0d]", i), seq_got[i], seq_exp[i]);
    wait_rx(9, 600);
    for (int i = 0; i < 9; i++)
      check_rx($sformatf("rr_byte[%0d]", i), i, bytes_exp[i]);
  endtask

  // 10-byte packet on ch1 into a 4-deep FIFO
  task automatic test_full();
    int idx;
    int maxl;
    int viol;
    int bad_gap;
    int k;
    do_reset();
    idx = 0; maxl = 0; viol = 0; k = 0;
    while (idx < 10 && k < 1000) begin
      tvalid      = 2'b10;
      tdata[15:8] = 8'(8'h30 + idx);
      tlast       = (idx == 9) ? 2'b10 : 2'b00;
      if (int'(level) > maxl) maxl = int'(level);
      if (level == 3'd4 && tready[1]) viol++;
      if (tready[1]) idx++;
      tick();
      k++;
    end
    tvalid = '0;
    tlast  = '0;
    check("full_bytes_taken", idx, 10);
    check("full_peak_level", maxl, 4);
    check("full_tready_low", viol, 0);
    wait_rx(10, 600);
    for (int i = 0; i < 10; i++)
      check_rx($sformatf("full_byte[%0d]", i), i, 8'(8'h30 + i));
    if (rx_start_q.size() >= 10) begin
      bad_gap = 0;
      for (int i = 0; i < 9; i++)
        if (rx_start_q[i+1] - rx_start_q[i] != 40) bad_gap++;
      check("full_back_to_back", bad_gap, 0);
      check("full_total_cycles", rx_start_q[9] + 40 - rx_start_q[0], 400);
    end else begin
      check("full_frames_seen", rx_start_q.size(), 10);
    end
  endtask

  // ch0 stalls 20 cycles mid-packet while ch1 waits
  task automatic test_stall();
    logic [7:0] bytes_exp[6] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50, 8'h51};
    int idx0, idx1, stall, r1_early, hold_bad, k;
    bit stalling, last0_done;
    do_reset();
    idx0 = 0; idx1 = 0; stall = 0; r1_early = 0; hold_bad = 0; k = 0;
    last0_done = 1'b0;
    while ((idx0 < 4 || idx1 < 2) && k < 2000) begin
      stalling    = (idx0 == 2 && stall < 20);
      tvalid[0]   = (idx0 < 4) && !stalling;
      tdata[7:0]  = 8'(8'h40 + idx0);
      tlast[0]    = (idx0 == 3);
      tvalid[1]   = (idx1 < 2);
      tdata[15:8] = 8'(8'h50 + idx1);
      tlast[1]    = (idx1 == 1);
      if (!last0_done && tready[1]) r1_early++;
      if (stalling) begin
        if (tready !== 2'b01) hold_bad++;
        stall++;
      end
      if (tvalid[0] && tready[0]) begin
        if (tlast[0]) last0_done = 1'b1;
        idx0++;
      end
      if (tvalid[1] && tready[1]) idx1++;
      tick();
      k++;
    end
    tvalid = '0;
    tlast  = '0;
    check("stall_ch0_bytes", idx0, 4);
    check("stall_ch1_bytes", idx1, 2);
    check("stall_cycles", stall, 20);
    check("stall_ch1_no_ready", r1_early, 0);
    check("stall_grant_held", hold_bad, 0);
    wait_rx(6, 800);
    for (int i = 0; i < 6; i++)
      check_rx($sformatf("stall_byte[%0d]", i), i, bytes_exp[i]);
  endtask

  // Reset asserted in the middle of a data bit
  task automatic test_reset_mid();
    int idx, k;
    do_reset();
    idx = 0; k = 0;
    while (idx < 3 && k < 50) begin
      tvalid     = 2'b01;
      tdata[7:0] = 8'(8'h60 + idx);
      tlast      = (idx == 2) ? 2'b01 : 2'b00;
      if (tready[0]) idx++;
      tick();
      k++;
    end
    tvalid = '0;
    tlast  = '0;
    k = 0;
    while (!(rx_busy && rx_pos >= 12) && k < 300) begin
      tick();
      k++;
    end
    check("rst_reached_data", rx_busy && rx_pos >= 12, 1'b1);
    check("rst_pre_level", level != 3'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_level", level, 3'd0);
    check("rst_mid_tready", tready, 2'b00);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    rx_q.delete();
    rx_start_q.delete();
    k = 0;
    idx = 0;
    while (idx < 1 && k < 20) begin
      tvalid      = 2'b10;
      tdata[15:8] = 8'h3C;
      tlast       = 2'b10;
      if (tready[1]) idx++;
      tick();
      k++;
    end
    tvalid = '0;
    tlast  = '0;
    check("rst_post_handshake", idx, 1);
    wait_rx(1, 100);
    repeat (100) tick();
    check("rst_post_count", rx_q.size(), 1);
    check_rx("rst_post_byte", 0, 8'h3C);
  endtask

  initial begin
    rst_n  = 1'b1;
    tvalid = '0;
    tlast  = '0;
    tdata  = '0;
    for (int r = 0; r < 43; r++) begin
      if (r < 2) begin
        vecs[r].tvalid     = 2'b01;
        vecs[r].tlast      = 2'b01;
        vecs[r].tdata      = 16'h00A5;
        vecs[r].exp_tx     = 1'b1;
        vecs[r].exp_tready = (r == 0) ? 2'b01 : 2'b00;
        vecs[r].exp_level  = (r == 0) ? 3'd0 : 3'd1;
      end else begin
        vecs[r].tvalid     = 2'b00;
        vecs[r].tlast      = 2'b00;
        vecs[r].tdata      = 16'h0000;
        vecs[r].exp_tx     = (r - 1 <= 40) ? 1'(fbits[(r - 2) / 4]) : 1'b1;
        vecs[r].exp_tready = 2'b00;
        vecs[r].exp_level  = 3'd0;
      end
    end

    // Asynchronous reset: outputs settle before any clock edge
    #3 rst_n = 1'b0;
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_tready", tready, 2'b00);
    check("reset_level", level, 3'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    test_single();
    test_rr();
    test_full();
    test_stall();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
